// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes rx_in, finds the start bit, samples each
// bit at mid-period using an external oversample tick, and checks the stop bit.
module uart_rx_deserializer #(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned CNT_WIDTH   = $clog2(OVERSAMPLE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic                   sample_tick,
  output logic [FRAME_WIDTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   frame_error,
  output logic                   busy
);

  localparam int unsigned BIT_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] MID_TICK  = CNT_WIDTH'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_TICK = CNT_WIDTH'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(FRAME_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [CNT_WIDTH-1:0]   tick_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [FRAME_WIDTH-1:0] shreg;

  // Both synchronizer stages reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (sample_tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_WIDTH'(1);
            end
          end
          DATA: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              shreg    <= {shreg[FRAME_WIDTH-2:0], rx_s};
              bit_cnt  <= bit_cnt + BIT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_WIDTH'(1);
            end
          end
          STOP: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (rx_s) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                state      <= IDLE;
                busy       <= 1'b0;
              end else begin
                frame_error <= 1'b1;
                state       <= WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_WIDTH'(1);
            end
          end
          WAIT_HIGH: begin
            // A held-low line (break) must return high before another start is accepted.
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
